// File: rtl/poly_sched_pkg.sv
// Shared opcode encodings, stage-count helper and FSM state type
// for the polynomial transform scheduler.
package poly_sched_pkg;

  localparam logic [1:0] OP_NTT  = 2'd0;
  localparam logic [1:0] OP_INTT = 2'd1;
  localparam logic [1:0] OP_PWM  = 2'd2;
  localparam logic [1:0] OP_RSV  = 2'd3;

  localparam int SW = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Index of the final stage: NTT/INTT run LOG_N-1 stages, PWM one.
  function automatic logic [SW-1:0] last_stage(
    input logic [1:0] op,
    input int         log_n
  );
    if (op == OP_PWM) return '0;
    return SW'(log_n - 2);
  endfunction

endpackage

// File: rtl/poly_sched_shift.sv
// Single-bit delay line of DEPTH cycles with synchronous flush.
// Ports: clk, rst (async high), flush_i, d_i in; q_o = d_i delayed DEPTH.
module poly_sched_shift #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sr_q;

  generate
    if (DEPTH == 1) begin : g_one
      always_ff @(posedge clk or posedge rst) begin
        if (rst)          sr_q <= '0;
        else if (flush_i) sr_q <= '0;
        else              sr_q <= d_i;
      end
    end else begin : g_many
      always_ff @(posedge clk or posedge rst) begin
        if (rst)          sr_q <= '0;
        else if (flush_i) sr_q <= '0;
        else              sr_q <= {sr_q[DEPTH-2:0], d_i};
      end
    end
  endgenerate

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/poly_sched.sv
// Stage/cycle scheduler for NTT, INTT and point-wise multiply passes.
// Ports: cmd handshake + abort in; opcode_q, i, s, ren/wen/en,
// busy, finish, err out. Bank writes trail reads by PIPE_LAT cycles.
module poly_sched
  import poly_sched_pkg::*;
#(
  parameter int LOG_N    = 8,
  parameter int P        = 4,
  parameter int PIPE_LAT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_opcode,
  input  logic                 abort,
  output logic [1:0]           opcode_q,
  output logic [$clog2((1<<LOG_N)/(2*P))-1:0] i,
  output logic [SW-1:0]        s,
  output logic                 ren,
  output logic                 wen,
  output logic                 en,
  output logic                 busy,
  output logic                 finish,
  output logic                 err
);

  localparam int C  = (1 << LOG_N) / (2 * P);
  localparam int IW = $clog2(C);

  localparam logic [IW-1:0] I_LAST = IW'(C - 1);
  localparam logic [4:0]    D_LAST = 5'(PIPE_LAT - 1);

  state_e          st_q;
  logic [4:0]      dcnt_q;
  logic [SW-1:0]   s_last;

  assign s_last = last_stage(opcode_q, LOG_N);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= ST_IDLE;
      i        <= '0;
      s        <= '0;
      dcnt_q   <= '0;
      opcode_q <= OP_NTT;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      if (abort) begin
        st_q   <= ST_IDLE;
        i      <= '0;
        s      <= '0;
        dcnt_q <= '0;
      end else begin
        unique case (st_q)
          ST_IDLE: begin
            if (cmd_valid) begin
              if (cmd_opcode == OP_RSV) begin
                err <= 1'b1;
              end else begin
                opcode_q <= cmd_opcode;
                i        <= '0;
                s        <= '0;
                st_q     <= ST_RUN;
              end
            end
          end
          ST_RUN: begin
            if (i == I_LAST) begin
              i      <= '0;
              dcnt_q <= '0;
              st_q   <= ST_DRAIN;
            end else begin
              i <= i + 1'b1;
            end
          end
          ST_DRAIN: begin
            if (dcnt_q == D_LAST) begin
              dcnt_q <= '0;
              if (s == s_last) begin
                st_q <= ST_DONE;
              end else begin
                s    <= s + 1'b1;
                st_q <= ST_RUN;
              end
            end else begin
              dcnt_q <= dcnt_q + 1'b1;
            end
          end
          ST_DONE: begin
            s    <= '0;
            st_q <= ST_IDLE;
          end
          default: st_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Abort flushes in-flight writes so nothing lands after cancel.
  poly_sched_shift #(
    .DEPTH (PIPE_LAT)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .flush_i (abort),
    .d_i     (ren),
    .q_o     (wen)
  );

  assign ren       = (st_q == ST_RUN);
  assign en        = ren | wen;
  assign busy      = (st_q != ST_IDLE);
  assign finish    = (st_q == ST_DONE);
  assign cmd_ready = (st_q == ST_IDLE) & ~abort;

endmodule

// File: doc/poly_sched.md
POLY_SCHED -- requirements
Module: poly_sched

Interface
REQ-001 Parameter LOG_N, default 8; log2 of polynomial length N.
REQ-002 Parameter P, default 4; coefficient pairs per cycle (power of 2, 2..16); 2P bank ports served per cycle.
REQ-003 Parameter PIPE_LAT, default 8; read-issue to bank-write latency in cycles (datapath L+1), range 1..31.
REQ-004 Derived: C = N/(2P) cycles per stage; IW = log2(C); NTT_STAGES = LOG_N-1; SW = 4.
REQ-005 clk  in  1  sole clock; all state changes on rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 cmd_valid  in  1  command request.
REQ-008 cmd_ready  out  1  high only in IDLE with abort low; transfer = cmd_valid & cmd_ready.
REQ-009 cmd_opcode  in  2  0=NTT, 1=INTT, 2=PWM, 3=reserved.
REQ-010 abort  in  1  synchronous cancel of the current command.
REQ-011 opcode_q  out  2  opcode latched at transfer; held until next transfer.
REQ-012 i  out  IW  in-stage cycle index for address/twiddle generators.
REQ-013 s  out  SW  current stage index.
REQ-014 ren  out  1  bank read enable / read-issue strobe.
REQ-015 wen  out  1  bank write enable, ren delayed PIPE_LAT cycles.
REQ-016 en  out  1  ren | wen.
REQ-017 busy  out  1  high whenever state is not IDLE.
REQ-018 finish  out  1  one-cycle pulse on completion.
REQ-019 err  out  1  one-cycle pulse when opcode 3 is presented with cmd_valid in IDLE.

Function
REQ-020 States: IDLE, RUN, DRAIN, DONE.
REQ-021 IDLE: a transfer with opcode 0..2 latches opcode_q, clears i and s, and enters RUN; opcode 3 is not accepted: cmd_ready stays high, err pulses on the next cycle, state stays IDLE.
REQ-022 Stage count: 7 stages (NTT_STAGES) for NTT/INTT; 1 stage for PWM.
REQ-023 RUN: ren=1 every cycle; i increments 0..C-1; after i=C-1, i wraps to 0 and state enters DRAIN.
REQ-024 DRAIN: ren=0 for exactly PIPE_LAT cycles so the last write of a stage lands before the next stage's first read.
REQ-025 End of DRAIN: if s is the last stage, enter DONE; otherwise increment s and enter RUN.
REQ-026 DONE: finish=1 for one cycle, s cleared, return to IDLE; cmd_ready is low in DONE.
REQ-027 wen(t) = ren(t-PIPE_LAT) exactly; no write is dropped or duplicated in normal operation.
REQ-028 Total latency, transfer edge to finish: stages*(C+PIPE_LAT)+1 cycles; with defaults, NTT = 281 and PWM = 41.
REQ-029 Abort in any state: next state is IDLE; i and s are cleared; the wen delay line is flushed so wen=0 from the next cycle; finish is not asserted.
REQ-030 Abort and cmd_valid in the same IDLE cycle: abort wins and no transfer occurs.
REQ-031 cmd_valid while busy is ignored and not queued.
REQ-032 Counters never exceed their range; i and s hold their values in IDLE and DONE.

Reset
REQ-033 While rst is high: state=IDLE, i=0, s=0, opcode_q=0, the delay line is cleared, and ren, wen, en, busy, finish and err are all 0.
REQ-034 cmd_ready=1 from the first clock after rst deasserts.
REQ-035 Reset mid-operation discards the command with no finish pulse; in-flight writes are lost.

Structure
REQ-036 Opcode encodings and the stage count belong in the shared parameter.v include; LOG_N, P and PIPE_LAT are module parameters.
REQ-037 The wen delay is one sub-module, shift (depth PIPE_LAT, width 1), extended with a synchronous flush input.
REQ-038 The FSM and the i/s counters live in poly_sched itself.
REQ-039 No combinational path from cmd_valid to any output other than through registered state; cmd_ready may depend combinationally on abort.

Verification
REQ-040 Defaults; rst released, NTT transfer at cycle 0 -> ren high cycles 1-32, 41-72, ...; wen mirrors ren +8; finish at cycle 281; 224 ren and 224 wen cycles in total.
REQ-041 PWM transfer -> s stays 0, 32 ren cycles, finish at cycle 41; then INTT back-to-back -> accepted the cycle after finish+1, with identical timing to NTT.
REQ-042 abort at RUN i=10 of stage 3 -> IDLE next cycle, wen=0 thereafter, no finish, and the next NTT timing is unchanged.
REQ-043 opcode 3 in IDLE -> err pulse, busy=0, no ren; abort+cmd_valid in the same cycle -> no transfer.
REQ-044 rst asserted asynchronously mid-DRAIN -> all outputs 0 immediately, without a clock edge.
REQ-045 Parameter sweep P=2/8/16, PIPE_LAT=1/31 -> wen = ren delayed by PIPE_LAT, and total latency matches REQ-028.
